// File: rtl/sigma_delta_diff.sv
// ============================================================================
//  sigma_delta_diff : third-order CIC (sinc^3) decimator, 1-bit in, 12-bit out
//  Revision 1.0
// ============================================================================
`default_nettype none

module sigma_delta_diff #(
    parameter int DECIM = 16,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [OUT_W-1:0] dout
);

    localparam int CNT_W = $clog2(DECIM);
    // Bit growth of a 3-stage CIC with 1-bit input: 1 + 3*log2(R).
    localparam int ACC_W = 1 + 3 * CNT_W;
    localparam logic [ACC_W-1:0] SAT = ACC_W'((1 << OUT_W) - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [ACC_W-1:0] i1, i2, i3;
    logic [ACC_W-1:0] d1, d2, d3;
    logic [ACC_W-1:0] c1, c2, c3;

    assign tick = (cnt == CNT_W'(DECIM - 1));

    // Modulo arithmetic: integrator wrap cancels exactly in the combs.
    assign c1 = i3 - d1;
    assign c2 = c1 - d2;
    assign c3 = c2 - d3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            i1   <= '0;
            i2   <= '0;
            i3   <= '0;
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
            dout <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            i1  <= i1 + {{(ACC_W-1){1'b0}}, din};
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            if (tick) begin
                d1   <= i3;
                d2   <= c1;
                d3   <= c2;
                // Full scale (R^3) does not fit OUT_W bits; clamp it.
                dout <= (c3 >= SAT) ? SAT[OUT_W-1:0] : c3[OUT_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sigma_delta_diff.sv
// ============================================================================
//  tb_sigma_delta_diff : directed vector bench for the sinc^3 decimator
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_sigma_delta_diff;

    logic        clk;
    logic        reset;
    logic        din;
    logic [11:0] dout;

    int errors = 0;
    int checks = 0;

    int obs [0:15];
    int pre15;

    sigma_delta_diff #(.DECIM(16), .OUT_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int tick;
        int expv;
    } vec_t;

    vec_t vecs [0:22];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // mode 0: zeros; 1: three ones; 2: all ones; 3: 1010..; 4: 1-in-4 then zeros after edge 96
    function automatic logic pat(input int mode, input int n);
        case (mode)
            1:       return (n <= 3);
            2:       return 1'b1;
            3:       return (n % 2 == 1);
            4:       return ((n % 4 == 1) && (n <= 96));
            default: return 1'b0;
        endcase
    endfunction

    // Edge n (n>=1) is the n-th rising edge after reset release; ticks at n = 16m.
    task automatic run_mode(input int mode, input int nedges);
        reset = 1'b0;
        din   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        din   = pat(mode, 1);
        for (int k = 0; k < 16; k++) obs[k] = -1;
        for (int n = 1; n <= nedges; n++) begin
            @(posedge clk);
            #1;
            if (n % 16 == 0) obs[n / 16] = int'(dout);
            if (n == 15) pre15 = int'(dout);
            if ((n % 16 == 8) && (n > 16))
                check($sformatf("hold_m%0d_e%0d", mode, n), int'(dout), obs[n / 16]);
            din = pat(mode, n + 1);
        end
    endtask

    initial begin
        int cur_mode;
        int sum;

        vecs[0]  = '{0, 1, 0};     vecs[1]  = '{0, 4, 0};     vecs[2]  = '{0, 10, 0};
        vecs[3]  = '{1, 1, 235};   vecs[4]  = '{1, 2, 514};   vecs[5]  = '{1, 3, 19};
        vecs[6]  = '{1, 4, 0};     vecs[7]  = '{1, 5, 0};     vecs[8]  = '{1, 8, 0};
        vecs[9]  = '{2, 1, 455};   vecs[10] = '{2, 2, 3130};  vecs[11] = '{2, 3, 4095};
        vecs[12] = '{2, 4, 4095};  vecs[13] = '{2, 8, 4095};
        vecs[14] = '{3, 4, 2048};  vecs[15] = '{3, 5, 2048};  vecs[16] = '{3, 6, 2048};
        vecs[17] = '{4, 4, 1024};  vecs[18] = '{4, 5, 1024};  vecs[19] = '{4, 6, 1024};
        vecs[20] = '{4, 9, 0};     vecs[21] = '{4, 10, 0};    vecs[22] = '{4, 11, 0};

        // Reset held low while din toggles: output must stay cleared.
        reset = 1'b0;
        din   = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            din = ~din;
        end
        check("reset_hold_dout", int'(dout), 0);

        cur_mode = -1;
        for (int v = 0; v < 23; v++) begin
            if (vecs[v].mode != cur_mode) begin
                cur_mode = vecs[v].mode;
                run_mode(cur_mode, 176);
                if (cur_mode == 1) begin
                    sum = 0;
                    for (int k = 1; k <= 11; k++) sum += obs[k];
                    check("impulse3_sum", sum, 768);
                end
                if (cur_mode == 2) check("no_update_before_tick", pre15, 0);
            end
            check($sformatf("vec%0d_mode%0d_tick%0d", v, vecs[v].mode, vecs[v].tick),
                  obs[vecs[v].tick], vecs[v].expv);
        end

        // Mid-operation asynchronous reset during all-ones steady state.
        run_mode(2, 100);
        check("steady_before_reset", int'(dout), 4095);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_clears", int'(dout), 0);
        run_mode(2, 80);
        check("resettle_tick1", obs[1], 455);
        check("resettle_tick2", obs[2], 3130);
        check("resettle_tick3", obs[3], 4095);
        check("resettle_tick5", obs[5], 4095);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
